// File: rtl/multiboot_ctrl.sv
// CPU-facing multiboot control: flash address register plus guarded reboot command
// that emits a stretched, registered REBOOT pulse for the ICAP sequencer.
module multiboot_ctrl #(
  parameter logic [7:0]  REG_MBADDR   = 8'hFB,
  parameter logic [7:0]  REG_MBCTRL   = 8'hFC,
  parameter logic [23:0] DEFAULT_ADDR = 24'h0BC000,
  parameter int          DELAY_CYCLES = 16,
  parameter int          PULSE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  zxuno_addr,
  input  logic        zxuno_regwr,
  input  logic        zxuno_regrd,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe,
  output logic [23:0] spi_addr,
  output logic        reboot
);

  localparam int CNT_MAX = (DELAY_CYCLES > PULSE_CYCLES) ? DELAY_CYCLES : PULSE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UNLK1 = 3'd1,
    UNLK2 = 3'd2,
    ARM   = 3'd3,
    PULSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reboot_d;

  logic       regwr_p0, regwr_p1;
  logic       regrd_p0, regrd_p1;
  logic [7:0] addr_p0, addr_p1;
  logic [7:0] din_p0;
  logic [1:0] ptr_q;
  logic [7:0] cur_byte;

  logic wr_ev, rd_end;
  logic wr_addr, wr_ctrl, rd_addr, rd_ctrl;
  logic frozen;

  // Stage p0/p1: strobe, address and data registered together so each event sees
  // the address that was present while its strobe was high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwr_p0 <= 1'b0;
      regwr_p1 <= 1'b0;
      regrd_p0 <= 1'b0;
      regrd_p1 <= 1'b0;
      addr_p0  <= 8'h00;
      addr_p1  <= 8'h00;
      din_p0   <= 8'h00;
    end else begin
      regwr_p0 <= zxuno_regwr;
      regwr_p1 <= regwr_p0;
      regrd_p0 <= zxuno_regrd;
      regrd_p1 <= regrd_p0;
      addr_p0  <= zxuno_addr;
      addr_p1  <= addr_p0;
      din_p0   <= din;
    end
  end

  assign wr_ev   = regwr_p0 & ~regwr_p1;
  assign rd_end  = ~regrd_p0 & regrd_p1;
  assign wr_addr = wr_ev  && (addr_p0 == REG_MBADDR);
  assign wr_ctrl = wr_ev  && (addr_p0 == REG_MBCTRL);
  assign rd_addr = rd_end && (addr_p1 == REG_MBADDR);
  assign rd_ctrl = rd_end && (addr_p1 == REG_MBCTRL);
  assign frozen  = (state_q == ARM) || (state_q == PULSE) || (state_q == DONE);

  assign oe = zxuno_regrd && ((zxuno_addr == REG_MBADDR) || (zxuno_addr == REG_MBCTRL));

  always_comb begin
    cur_byte = spi_addr[7:0];
    case (ptr_q)
      2'd1:    cur_byte = spi_addr[15:8];
      2'd2:    cur_byte = spi_addr[23:16];
      default: cur_byte = spi_addr[7:0];
    endcase
  end

  // Byte pointer: control-register traffic resynchronises it to byte 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else if (wr_ctrl || rd_ctrl) begin
      ptr_q <= 2'd0;
    end else if ((wr_addr && !frozen) || rd_addr) begin
      ptr_q <= (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_addr <= DEFAULT_ADDR;
    end else if (wr_addr && !frozen) begin
      case (ptr_q)
        2'd1:    spi_addr[15:8]  <= din_p0;
        2'd2:    spi_addr[23:16] <= din_p0;
        default: spi_addr[7:0]   <= din_p0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 8'h00;
    end else if (zxuno_regrd) begin
      if (zxuno_addr == REG_MBADDR) begin
        dout <= cur_byte;
      end else if (zxuno_addr == REG_MBCTRL) begin
        dout <= {5'b00000, state_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      reboot  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reboot  <= reboot_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reboot_d = reboot;
    case (state_q)
      IDLE: begin
        if (wr_ctrl && (din_p0 == 8'hA5)) state_d = UNLK1;
      end
      UNLK1: begin
        if (wr_ctrl) state_d = (din_p0 == 8'h5A) ? UNLK2 : IDLE;
      end
      UNLK2: begin
        if (wr_ctrl) begin
          if (din_p0 == 8'h01) begin
            state_d = ARM;
            cnt_d   = DELAY_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ARM: begin
        if (cnt_q == CNT_ZERO) begin
          reboot_d = 1'b1;
          cnt_d    = PULSE_LOAD;
          state_d  = PULSE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_ZERO) begin
          reboot_d = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d  = IDLE;
        reboot_d = 1'b0;
      end
    endcase
  end

endmodule
